// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a 5-stage MIPS pipeline.
// Produces registered EX-stage operand-select codes (00 = register file,
// 01 = EX/MEM result, 10 = MEM/WB result), a combinational load-use stall,
// and a saturating count of stall cycles.
//
// The unit shadows the EX and MEM occupants of the pipeline. A WB shadow is
// not kept: once an instruction is in WB its result is already in the
// register file for a reader entering EX, so it can never be the source of
// a forward. For the same reason the MEM shadow drops the load flag, because
// a load's data is available for forwarding from MEM/WB.
module fwd_hazard_unit #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic              stall,
   output logic [1:0]        sel_a,
   output logic [1:0]        sel_b,
   output logic              ex_valid,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [1:0] SEL_RF    = 2'b00;
   localparam logic [1:0] SEL_EXMEM = 2'b01;
   localparam logic [1:0] SEL_MEMWB = 2'b10;

   // EX shadow slot
   logic              ex_valid_q, ex_valid_d;
   logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
   logic              ex_rw_q, ex_rw_d;
   logic              ex_mr_q, ex_mr_d;

   // MEM shadow slot
   logic              mem_valid_q, mem_valid_d;
   logic [REG_AW-1:0] mem_dst_q, mem_dst_d;
   logic              mem_rw_q, mem_rw_d;

   // Registered outputs
   logic [1:0]        sel_a_q, sel_a_d;
   logic [1:0]        sel_b_q, sel_b_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Hazard detection and per-operand source matches
   logic haz;
   logic load_real;
   logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

   // Select code for one operand; the younger EX/MEM result beats MEM/WB.
   function automatic logic [1:0] pick_sel(input logic ex_hit, input logic mem_hit);
      if (ex_hit) begin
         return SEL_EXMEM;
      end else if (mem_hit) begin
         return SEL_MEMWB;
      end else begin
         return SEL_RF;
      end
   endfunction

   // Detect a load in EX feeding the ID instruction, and find which in-flight slots write each source
   always_comb begin
      haz = id_valid & ex_valid_q & ex_mr_q & ex_rw_q & (ex_dst_q != '0) &
            ((ex_dst_q == id_rs) | (ex_dst_q == id_rt));
      ex_hit_a  = ex_valid_q  & ex_rw_q  & (ex_dst_q  == id_rs) & (id_rs != '0);
      ex_hit_b  = ex_valid_q  & ex_rw_q  & (ex_dst_q  == id_rt) & (id_rt != '0);
      mem_hit_a = mem_valid_q & mem_rw_q & (mem_dst_q == id_rs) & (id_rs != '0);
      mem_hit_b = mem_valid_q & mem_rw_q & (mem_dst_q == id_rt) & (id_rt != '0);
      stall     = haz & ~flush & ~reset;
      load_real = id_valid & ~stall & ~flush;
   end

   // Next-state: advance the shadow pipeline, load EX with the ID instruction or a bubble, bump the stall counter
   always_comb begin
      mem_valid_d = ex_valid_q;
      mem_dst_d   = ex_dst_q;
      mem_rw_d    = ex_rw_q;
      ex_valid_d  = 1'b0;
      ex_dst_d    = '0;
      ex_rw_d     = 1'b0;
      ex_mr_d     = 1'b0;
      sel_a_d     = SEL_RF;
      sel_b_d     = SEL_RF;
      cnt_d       = cnt_q;
      if (load_real) begin
         ex_valid_d = 1'b1;
         ex_dst_d   = id_dst;
         ex_rw_d    = id_reg_write;
         ex_mr_d    = id_mem_read;
         sel_a_d    = pick_sel(ex_hit_a, mem_hit_a);
         sel_b_d    = pick_sel(ex_hit_b, mem_hit_b);
      end
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // State registers; reset clears every slot and output
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q  <= 1'b0;
         ex_dst_q    <= '0;
         ex_rw_q     <= 1'b0;
         ex_mr_q     <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_dst_q   <= '0;
         mem_rw_q    <= 1'b0;
         sel_a_q     <= SEL_RF;
         sel_b_q     <= SEL_RF;
         cnt_q       <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_dst_q    <= ex_dst_d;
         ex_rw_q     <= ex_rw_d;
         ex_mr_q     <= ex_mr_d;
         mem_valid_q <= mem_valid_d;
         mem_dst_q   <= mem_dst_d;
         mem_rw_q    <= mem_rw_d;
         sel_a_q     <= sel_a_d;
         sel_b_q     <= sel_b_d;
         cnt_q       <= cnt_d;
      end
   end

   assign sel_a       = sel_a_q;
   assign sel_b       = sel_b_q;
   assign ex_valid    = ex_valid_q;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: a hand-derived vector table,
// hand-written stall/saturation/reset sequences, then random traffic checked
// against a queue-based model of the in-flight instructions.
module tb_fwd_hazard_unit;

   logic       clk;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_dst;
   logic       id_reg_write, id_mem_read, flush;

   logic        stall, ex_valid;
   logic [1:0]  sel_a, sel_b;
   logic [15:0] stall_count;

   logic        s_stall, s_ex_valid;
   logic [1:0]  s_sel_a, s_sel_b;
   logic [1:0]  s_stall_count;

   int total;
   int bad;

   fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .flush(flush), .stall(stall), .sel_a(sel_a), .sel_b(sel_b),
      .ex_valid(ex_valid), .stall_count(stall_count)
   );

   fwd_hazard_unit #(.REG_AW(5), .CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .flush(flush), .stall(s_stall), .sel_a(s_sel_a), .sel_b(s_sel_b),
      .ex_valid(s_ex_valid), .stall_count(s_stall_count)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [4:0]  rs, rt, dst;
      logic        rw, mr, fl, rst;
      logic        e_stall;
      logic [1:0]  e_a, e_b;
      logic        e_exv;
      logic [15:0] e_cnt;
   } vec_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       rw, mr;
   } ent_t;

   // Reference model: hist[0] is the instruction now in EX, hist[1] the one in MEM
   ent_t       hist[$];
   logic [1:0] m_a, m_b;
   logic       m_exv;
   int         m_cnt;

   function automatic vec_t mk(input logic v, input int rs, input int rt, input int dst,
                               input logic rw, input logic mr, input logic fl, input logic rst,
                               input logic e_stall, input logic [1:0] e_a, input logic [1:0] e_b,
                               input logic e_exv, input int e_cnt);
      vec_t t;
      t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.dst = 5'(dst);
      t.rw = rw; t.mr = mr; t.fl = fl; t.rst = rst;
      t.e_stall = e_stall; t.e_a = e_a; t.e_b = e_b; t.e_exv = e_exv; t.e_cnt = 16'(e_cnt);
      return t;
   endfunction

   function automatic logic writes(input ent_t e, input logic [4:0] r);
      return e.valid && e.rw && (e.dst == r) && (r != 5'd0);
   endfunction

   function automatic logic model_stall();
      ent_t e;
      e = hist[0];
      return id_valid && !reset && !flush && e.valid && e.mr && e.rw && (e.dst != 5'd0) &&
             ((e.dst == id_rs) || (e.dst == id_rt));
   endfunction

   // Distance back to the youngest in-flight writer of r picks the code
   function automatic logic [1:0] model_sel(input logic [4:0] r);
      for (int i = 0; i < 2; i++) begin
         if (writes(hist[i], r)) return 2'(i + 1);
      end
      return 2'b00;
   endfunction

   task automatic model_reset();
      ent_t b;
      b = '0;
      hist.delete();
      hist.push_back(b);
      hist.push_back(b);
      m_a = 2'b00; m_b = 2'b00; m_exv = 1'b0; m_cnt = 0;
   endtask

   task automatic model_step();
      ent_t n;
      logic s, real_ins;
      if (reset) begin
         model_reset();
      end else begin
         s = model_stall();
         real_ins = id_valid && !s && !flush;
         n = '0;
         m_a = 2'b00; m_b = 2'b00;
         if (real_ins) begin
            m_a = model_sel(id_rs);
            m_b = model_sel(id_rt);
            n.valid = 1'b1; n.dst = id_dst; n.rw = id_reg_write; n.mr = id_mem_read;
         end
         m_exv = real_ins;
         hist.push_front(n);
         void'(hist.pop_back());
         if (s) m_cnt++;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle: drive, check stall before the edge, advance model, check registered outputs after
   task automatic applyStimulus(input vec_t t, input logic use_tbl, input string tag);
      logic        e_stall, e_exv;
      logic [1:0]  e_a, e_b;
      int          e_cnt;
      id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_dst = t.dst;
      id_reg_write = t.rw; id_mem_read = t.mr; flush = t.fl; reset = t.rst;
      #4;
      e_stall = use_tbl ? t.e_stall : model_stall();
      checkOutput({tag, " stall"}, 32'(stall), 32'(e_stall));
      checkOutput({tag, " stall_small"}, 32'(s_stall), 32'(e_stall));
      @(posedge clk);
      model_step();
      #1;
      if (use_tbl) begin
         e_a = t.e_a; e_b = t.e_b; e_exv = t.e_exv; e_cnt = int'(t.e_cnt);
      end else begin
         e_a = m_a; e_b = m_b; e_exv = m_exv; e_cnt = (m_cnt > 65535) ? 65535 : m_cnt;
      end
      checkOutput({tag, " sel_a"}, 32'(sel_a), 32'(e_a));
      checkOutput({tag, " sel_b"}, 32'(sel_b), 32'(e_b));
      checkOutput({tag, " ex_valid"}, 32'(ex_valid), 32'(e_exv));
      checkOutput({tag, " stall_count"}, 32'(stall_count), 32'(e_cnt));
      checkOutput({tag, " stall_count_small"}, 32'(s_stall_count), 32'((e_cnt > 3) ? 3 : e_cnt));
   endtask

   vec_t tbl[20];
   int   sat_exp[4] = '{1, 2, 3, 3};

   initial begin
      total = 0;
      bad = 0;
      model_reset();
      reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dst = '0;
      id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
      @(posedge clk);
      #1;

      //          v   rs rt dst rw mr fl rst  stall a      b      exv cnt
      tbl[0]  = mk(0,  0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 0, 0);
      tbl[1]  = mk(0,  0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0);
      tbl[2]  = mk(1,  1, 2, 8, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 0);
      tbl[3]  = mk(1,  8, 9,10, 1, 0, 0, 0,  0, 2'b01, 2'b00, 1, 0);
      tbl[4]  = mk(1,  0, 0, 8, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 0);
      tbl[5]  = mk(0,  0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0);
      tbl[6]  = mk(1,  8, 9,11, 1, 0, 0, 0,  0, 2'b10, 2'b00, 1, 0);
      tbl[7]  = mk(1,  3, 4, 8, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 0);
      tbl[8]  = mk(1,  5, 6, 8, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 0);
      tbl[9]  = mk(1,  8, 8,12, 1, 0, 0, 0,  0, 2'b01, 2'b01, 1, 0);
      tbl[10] = mk(1,  1, 1, 0, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 0);
      tbl[11] = mk(1,  0, 8,13, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 0);
      tbl[12] = mk(1,  1, 0, 5, 1, 1, 0, 0,  0, 2'b00, 2'b00, 1, 0);
      tbl[13] = mk(1,  2, 5, 6, 1, 0, 0, 0,  1, 2'b00, 2'b00, 0, 1);
      tbl[14] = mk(1,  2, 5, 6, 1, 0, 0, 0,  0, 2'b00, 2'b10, 1, 1);
      tbl[15] = mk(1,  0, 0, 5, 1, 1, 0, 0,  0, 2'b00, 2'b00, 1, 1);
      tbl[16] = mk(1,  5, 2, 7, 1, 0, 1, 0,  0, 2'b00, 2'b00, 0, 1);
      tbl[17] = mk(0,  0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 1);
      tbl[18] = mk(1,  1, 2, 5, 1, 1, 0, 0,  0, 2'b00, 2'b00, 1, 1);
      tbl[19] = mk(1,  5, 5, 7, 1, 0, 0, 1,  0, 2'b00, 2'b00, 0, 0);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(tbl[i], 1'b1, $sformatf("vec%0d", i));
      end

      // Four load-use stalls: the 2-bit counter saturates at 3, the 16-bit one keeps counting
      for (int k = 0; k < 4; k++) begin
         applyStimulus(mk(1, 1, 2, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0), 1'b0, $sformatf("sat%0d_lw", k));
         applyStimulus(mk(1, 5, 3, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), 1'b0, $sformatf("sat%0d_stall", k));
         checkOutput($sformatf("sat%0d small_count", k), 32'(s_stall_count), 32'(sat_exp[k]));
         checkOutput($sformatf("sat%0d big_count", k), 32'(stall_count), 32'(k + 1));
         applyStimulus(mk(1, 5, 3, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), 1'b0, $sformatf("sat%0d_acc", k));
         checkOutput($sformatf("sat%0d fwd_memwb", k), 32'(sel_a), 32'(2'b10));
      end

      // Reset arriving while a load-use hazard is present wipes everything
      applyStimulus(mk(1, 1, 2, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0), 1'b0, "rst_lw");
      applyStimulus(mk(1, 5, 5, 6, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0), 1'b0, "rst_hit");
      checkOutput("rst_hit zero_count", 32'(stall_count), 32'd0);
      checkOutput("rst_hit zero_small", 32'(s_stall_count), 32'd0);
      checkOutput("rst_hit zero_exv", 32'(ex_valid), 32'd0);
      applyStimulus(mk(1, 5, 5, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), 1'b0, "rst_after");
      checkOutput("rst_after no_fwd", 32'(sel_a), 32'd0);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         vec_t r;
         r = '0;
         r.v   = ($urandom_range(0, 3) != 0);
         r.rs  = 5'($urandom_range(0, 7));
         r.rt  = 5'($urandom_range(0, 7));
         r.dst = 5'($urandom_range(0, 7));
         r.rw  = ($urandom_range(0, 4) != 0);
         r.mr  = ($urandom_range(0, 2) == 0);
         r.fl  = ($urandom_range(0, 7) == 0);
         r.rst = ($urandom_range(0, 63) == 0);
         applyStimulus(r, 1'b0, $sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
